// File: rtl/adder_sum_stage.sv
// rtl/adder_sum_stage.sv - prefix adder sum/flag stage with 2-entry skid output (opt. ADDER_SUM_STICKY_OVF_EN)
`ifndef LEN_DATA
`define LEN_DATA 31
`endif

module adder_sum_stage #(
    parameter int W = `LEN_DATA + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] grp_g,
    input  logic [W-1:0] grp_p,
    input  logic [W-1:0] bit_p,
    input  logic         cin,
    input  logic [1:0]   op_size,
`ifdef ADDER_SUM_STICKY_OVF_EN
    input  logic         ovf_clr,
    output logic         ovf_sticky,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_c,
    output logic         out_v,
    output logic         out_z,
    output logic         out_n
);

    generate
        if ((W % 2) != 0 || W < 16) begin : g_bad_width
            $error("adder_sum_stage: W must be even and >= 16");
        end
    endgenerate

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } res_t;

    logic [W:0]   carry;
    logic [W-1:0] raw;
    res_t         nxt;
    res_t         m_q;
    res_t         s_q;
    logic         m_valid;
    logic         s_valid;
    logic         in_xfer;
    logic         out_xfer;

    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = grp_g[i] | (grp_p[i] & cin);
        end
        raw = bit_p ^ carry[W-1:0];
    end

    // Narrow widths zero the upper sum bits so flags only see the selected field.
    always_comb begin
        nxt = '0;
        case (op_size)
            2'd0: begin
                nxt.sum = W'(raw[7:0]);
                nxt.c   = carry[8];
                nxt.v   = carry[8] ^ carry[7];
                nxt.n   = raw[7];
            end
            2'd1: begin
                nxt.sum = W'(raw[15:0]);
                nxt.c   = carry[16];
                nxt.v   = carry[16] ^ carry[15];
                nxt.n   = raw[15];
            end
            default: begin
                nxt.sum = raw;
                nxt.c   = carry[W];
                nxt.v   = carry[W] ^ carry[W-1];
                nxt.n   = raw[W-1];
            end
        endcase
        nxt.z = (nxt.sum == '0);
    end

    assign in_ready = ~s_valid;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = m_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (!m_valid || out_xfer) begin
            if (s_valid) begin
                m_q     <= s_q;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_xfer) begin
                m_q     <= nxt;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            s_q     <= nxt;
            s_valid <= 1'b1;
        end
    end

`ifdef ADDER_SUM_STICKY_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end else if (out_xfer && m_q.v) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

    assign out_valid = m_valid;
    assign out_sum   = m_q.sum;
    assign out_c     = m_q.c;
    assign out_v     = m_q.v;
    assign out_z     = m_q.z;
    assign out_n     = m_q.n;

endmodule

// File: tb/tb_adder_sum_stage.sv
// tb/tb_adder_sum_stage.sv - scoreboard bench for adder_sum_stage against an arithmetic model
module tb_adder_sum_stage;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic c, v, z, n;
    } exp_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] grp_g = '0, grp_p = '0, bit_p = '0;
    logic         cin = 0;
    logic [1:0]   op_size = 0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [W-1:0] out_sum;
    logic         out_c, out_v, out_z, out_n;
`ifdef ADDER_SUM_STICKY_OVF_EN
    logic         ovf_clr = 0;
    logic         ovf_sticky;
`endif

    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 0;
    exp_t q[$];

    adder_sum_stage #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .grp_g(grp_g), .grp_p(grp_p), .bit_p(bit_p), .cin(cin), .op_size(op_size),
`ifdef ADDER_SUM_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic [1:0] op);
        exp_t   e;
        int     wd;
        longint m, s;
        wd    = (op == 0) ? 8 : (op == 1) ? 16 : W;
        m     = (longint'(1) << wd) - 1;
        s     = (longint'(a) & m) + (longint'(b) & m) + longint'(ci);
        e.sum = W'(s & m);
        e.c   = s[wd];
        e.n   = e.sum[wd-1];
        e.v   = (a[wd-1] == b[wd-1]) && (e.sum[wd-1] != a[wd-1]);
        e.z   = (e.sum == '0);
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [1:0] op);
        longint mi;
        bit     done = 0;
        for (int i = 0; i < W; i++) begin
            mi       = (longint'(1) << (i + 1)) - 1;
            grp_g[i] = ((((longint'(a) & mi) + (longint'(b) & mi)) >> (i + 1)) & 1) != 0;
            grp_p[i] = ((longint'(a ^ b) & mi) == mi);
        end
        bit_p    = a ^ b;
        cin      = ci;
        op_size  = op;
        in_valid = 1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) begin
                q.push_back(model(a, b, ci, op));
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 0;
        grp_g    = $urandom;
        grp_p    = $urandom;
        bit_p    = $urandom;
    endtask

    task automatic check_out(input string name, input exp_t e);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_sum"}, out_sum, e.sum);
        check({name, "_flags"}, {out_c, out_v, out_z, out_n}, {e.c, e.v, e.z, e.n});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_beat: got sum 0x%0h with no beat outstanding", out_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({out_sum, out_c, out_v, out_z, out_n} != e) begin
                    errors++;
                    $display("FAIL scoreboard: got sum=0x%0h cvzn=%b%b%b%b expected sum=0x%0h cvzn=%b%b%b%b",
                             out_sum, out_c, out_v, out_z, out_n, e.sum, e.c, e.v, e.z, e.n);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        exp_t cst;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_sum", out_sum, 0);
        check("reset_flags", {out_c, out_v, out_z, out_n}, 0);
        rst_n = 1;
        @(negedge clk);

        out_ready = 1;
        send(32'hFFFF_FFFF, 32'h1, 0, 2);
        cst = '{sum: 32'h0, c: 1, v: 0, z: 1, n: 0};
        check_out("full_wrap", cst);
        send(32'h7F, 32'h01, 0, 0);
        cst = '{sum: 32'h80, c: 0, v: 1, z: 0, n: 1};
        check_out("byte_ovf", cst);
        send(32'h5, 32'hFFF8, 1, 1);
        cst = '{sum: 32'hFFFE, c: 0, v: 0, z: 0, n: 1};
        check_out("half_sub", cst);
        @(negedge clk);

        out_ready = 0;
        send(32'd1, 32'd0, 0, 2);
        send(32'd2, 32'd0, 0, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold_sum", out_sum, 1);
        @(negedge clk);
        check("bp_hold_sum2", out_sum, 1);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1;
        send(32'd3, 32'd0, 0, 2);
        send(32'd4, 32'd0, 0, 2);
        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        check("bp_drained", q.size(), 0);

        out_ready = 0;
        send(32'd10, 32'd5, 0, 2);
        send(32'd20, 32'd5, 0, 2);
        rst_n = 0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst_n     = 1;
        out_ready = 1;
        repeat (5) @(negedge clk);
        check("rst_no_stale", out_valid, 0);

`ifdef ADDER_SUM_STICKY_OVF_EN
        send(32'h7F, 32'h01, 0, 0);
        @(negedge clk);
        check("sticky_set", ovf_sticky, 1);
        send(32'h1, 32'h1, 0, 2);
        @(negedge clk);
        check("sticky_hold", ovf_sticky, 1);
        send(32'h7FFF, 32'h1, 0, 1);
        ovf_clr = 1;
        @(negedge clk);
        ovf_clr = 0;
        check("sticky_clr_prio", ovf_sticky, 0);
`endif

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        @(negedge clk);
        rand_ready = 0;
        out_ready  = 1;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        check("final_drain", q.size(), 0);
        repeat (2) @(negedge clk);
        check("final_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
